// File: rtl/pipe_ctrl.sv
// Pipeline latch/PC sequencer: advance, freeze or bubble each latch, own the
// data-memory handshake and count stalled cycles.
//
// state | meaning
// RUN   | normal operation; data request driven for the EX/MEM memop
// DHELD | data access done, waiting on fetch; request suppressed
// HALT  | CPU halted; everything frozen until reset
module pipe_ctrl #(
  parameter int CNT_W = 16,
  parameter int REG_W = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmemr_mem,
  input  logic             dmemw_mem,
  input  logic             halt_mem,
  input  logic             redirect_mem,
  input  logic             dmemr_exe,
  input  logic [REG_W-1:0] rd_exe,
  input  logic [REG_W-1:0] rs1_dec,
  input  logic [REG_W-1:0] rs2_dec,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic             dload_cap,
  output logic             pc_en,
  output logic             en_ifid,
  output logic             en_idex,
  output logic             en_exmem,
  output logic             en_memwb,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_exmem,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DHELD = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             run, dheld, memop, adv, load_use;

  always_comb begin
    run      = (state_q == S_RUN);
    dheld    = (state_q == S_DHELD);
    memop    = dmemr_mem | dmemw_mem;
    adv      = ihit & (~memop | dhit | dheld) & (run | dheld);
    load_use = dmemr_exe & (rd_exe != '0) & ((rd_exe == rs1_dec) | (rd_exe == rs2_dec));

    dmemREN     = 1'b0;
    dmemWEN     = 1'b0;
    dload_cap   = 1'b0;
    pc_en       = 1'b0;
    en_ifid     = 1'b0;
    en_idex     = 1'b0;
    en_exmem    = 1'b0;
    en_memwb    = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;

    // Outputs are gated by RST so a request drops the moment reset asserts.
    if (!RST) begin
      dmemREN   = run & dmemr_mem;
      dmemWEN   = run & dmemw_mem;
      dload_cap = run & dhit & dmemr_mem;
      if (adv) begin
        pc_en    = 1'b1;
        en_ifid  = 1'b1;
        en_idex  = 1'b1;
        en_exmem = 1'b1;
        en_memwb = 1'b1;
        if (redirect_mem) begin
          flush_ifid  = 1'b1;
          flush_idex  = 1'b1;
          flush_exmem = 1'b1;
        end else if (load_use) begin
          pc_en      = 1'b0;
          en_ifid    = 1'b0;
          flush_idex = 1'b1;
        end
      end
    end

    state_d = state_q;
    case (state_q)
      S_RUN: begin
        if (memop & dhit & ~ihit)   state_d = S_DHELD;
        else if (adv & halt_mem)    state_d = S_HALT;
      end
      S_DHELD: if (ihit) state_d = S_RUN;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RUN;
    endcase

    stall_cnt_d = stall_cnt_q;
    if ((run | dheld) & ~adv & ~(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign halt      = (state_q == S_HALT);
  assign stall_cnt = stall_cnt_q;

endmodule
